bus_master_port: RTL

- Master-side serial port; the stage directly upstream of the slave port on the serial bus.
- Accepts a parallel read/write request from the local master. Serialises the 12-bit address and 8-bit write data LSB-first, with a valid/ready and enable handshake.
- For reads, waits through any slave split and deserialises the 8-bit read data returned by the slave.
- Returns a one-cycle completion pulse to the local master.

---
 rtl/bus_master_port.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
// bus_master_port : master-side serial port; serialises address/write data
// LSB-first and deserialises read data. Optional macro BUS_MASTER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module bus_master_port #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    input  logic                  split_en,
    input  logic                  rx_data,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  master_valid,
    output logic                  master_ready,
    output logic                  read_en,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  error,
    output logic                  busy
);

    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] C_DATA_BITS = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_RD_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_sh_q;
    logic [DATA_WIDTH-1:0]   wdata_sh_q;
    logic [DATA_WIDTH-1:0]   rx_sh_q;
    logic                    mode_q;
    logic                    tx_address_q;
    logic                    tx_data_q;
    logic                    master_valid_q;
    logic                    master_ready_q;
    logic                    read_en_q;
    logic                    write_en_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    done_q;
    logic                    error_q;
    logic                    busy_q;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;
`else
    logic w_unused_split;
    assign w_unused_split = split_en ^ (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            addr_sh_q      <= '0;
            wdata_sh_q     <= '0;
            rx_sh_q        <= '0;
            mode_q         <= 1'b0;
            tx_address_q   <= 1'b0;
            tx_data_q      <= 1'b0;
            master_valid_q <= 1'b0;
            master_ready_q <= 1'b0;
            read_en_q      <= 1'b0;
            write_en_q     <= 1'b0;
            rdata_q        <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req && slave_ready) begin
                        mode_q         <= mode;
                        addr_sh_q      <= addr_in >> 1;
                        wdata_sh_q     <= mode ? (wdata_in >> 1) : '0;
                        tx_address_q   <= addr_in[0];
                        tx_data_q      <= mode & wdata_in[0];
                        master_valid_q <= 1'b1;
                        read_en_q      <= ~mode;
                        write_en_q     <= mode;
                        busy_q         <= 1'b1;
                        bit_cnt_q      <= CNT_W'(1);
                        state_q        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bit_cnt_q >= C_ADDR_LAST) begin
                        master_valid_q <= 1'b0;
                        tx_address_q   <= 1'b0;
                        tx_data_q      <= 1'b0;
                        bit_cnt_q      <= '0;
                        rx_sh_q        <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
                        to_cnt_q       <= '0;
`endif
                        if (mode_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            master_ready_q <= 1'b1;
                            state_q        <= S_RD_WAIT;
                        end
                    end else begin
                        // bit_cnt_q equals the index of the bit going out next
                        tx_address_q <= addr_sh_q[0];
                        addr_sh_q    <= addr_sh_q >> 1;
                        tx_data_q    <= (bit_cnt_q < C_DATA_BITS) ? wdata_sh_q[0] : 1'b0;
                        wdata_sh_q   <= wdata_sh_q >> 1;
                        bit_cnt_q    <= bit_cnt_q + 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (slave_valid) begin
                        rx_sh_q <= {rx_data, rx_sh_q[DATA_WIDTH-1:1]};
`ifdef BUS_MASTER_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        if (bit_cnt_q >= C_DATA_LAST) begin
                            rdata_q        <= {rx_data, rx_sh_q[DATA_WIDTH-1:1]};
                            master_ready_q <= 1'b0;
                            done_q         <= 1'b1;
                            bit_cnt_q      <= '0;
                            state_q        <= S_DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
`ifdef BUS_MASTER_TIMEOUT_EN
                    else if (!split_en) begin
                        // abort on the edge where the idle count would hit the limit
                        if (to_cnt_q >= C_TO_LAST) begin
                            master_ready_q <= 1'b0;
                            done_q         <= 1'b1;
                            error_q        <= 1'b1;
                            bit_cnt_q      <= '0;
                            state_q        <= S_DONE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_address   = tx_address_q;
    assign tx_data      = tx_data_q;
    assign master_valid = master_valid_q;
    assign master_ready = master_ready_q;
    assign read_en      = read_en_q;
    assign write_en     = write_en_q;
    assign rdata        = rdata_q;
    assign done         = done_q;
    assign error        = error_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire
